pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards between ID and EX.
- Sequences D-cache miss freezes and branch-mispredict flushes.
- Drives the hazard, flush and memhazard controls of the ID/EX register, plus the PC and IF/ID hold/kill controls.
- Keeps stall/flush performance counters and a miss-timeout error flag.

Parameters:
FLUSH_CYCLES, 1, cycles flush is held after a mispredict (1..7)
MISS_TIMEOUT, 255, D-cache stall cycles before err_timeout sets (8-bit compare)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_rs1  in  5  rs1 field of instruction in ID
id_rs2  in  5  rs2 field of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_mispredict  in  1  EX branch/jump resolved target != predictpcE
dcache_req  in  1  MEM stage has a valid D-cache access
dcache_ready  in  1  D-cache hit/refill complete this cycle
icache_ready  in  1  I-cache delivers instruction this cycle
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
if_kill  out  1  load a bubble into IF/ID
hazard  out  1  insert bubble into ID/EX
flush  out  1  kill ID/EX contents
memhazard  out  1  freeze ID/EX and later stages
busy_state  out  2  current FSM state (00 RUN, 01 DMISS, 10 FLUSH)
err_timeout  out  1  sticky: miss exceeded MISS_TIMEOUT
stall_cnt  out  32  cycles with memhazard or hazard asserted
flush_cnt  out  32  mispredict flush events

Behaviour:
- Registered: state, flush counter fcnt (3b), miss counter mcnt (8b), pend_flush, err_timeout, stall_cnt, flush_cnt. All outputs are combinational from state and current inputs, so the ID/EX register acts at the same posedge.
- Reset: state=RUN, fcnt=0, mcnt=0, pend_flush=0, err_timeout=0, both counters=0. All control outputs are 0 while in RUN with idle inputs.
- Load-use term: lu = ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Output priority: memhazard > flush > hazard. At most one of the three is 1 in any cycle.

RUN:
- dcache_req & !dcache_ready:
  - memhazard=1, stall_if=1, stall_id=1.
  - Next state DMISS, mcnt=1.
  - If ex_mispredict is also 1 this cycle, set pend_flush=1. Do not flush now, because EX is frozen.
- else ex_mispredict | pend_flush:
  - flush=1, if_kill=1.
  - flush_cnt+=1, pend_flush cleared.
  - If FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1.
  - Suppresses lu.
- else lu: hazard=1, stall_if=1, stall_id=1 for exactly one cycle. Next cycle lu drops because the load has moved to MEM.
- !icache_ready (independent): stall_if=1 and if_kill=1 unless stall_id=1. If stall_id=1, IF/ID holds instead.

DMISS:
- memhazard=1, stall_if=1, stall_id=1 every cycle, including the cycle dcache_ready=1. The freeze releases at the next edge.
- Each cycle: mcnt saturating +1. When mcnt==MISS_TIMEOUT, err_timeout=1 (sticky until rst). State does not change.
- dcache_ready=1: next state RUN, mcnt=0. A captured pend_flush fires in the first RUN cycle.
- ex_mispredict in DMISS sets pend_flush.

FLUSH:
- flush=1, if_kill=1. fcnt-=1. At fcnt==1, next state RUN.
- A new dcache miss in FLUSH is deferred until RUN.

Counters and reset:
- stall_cnt += 1 per cycle with memhazard|hazard. Both counters wrap at 2^32 with no saturation.
- rst mid-DMISS or mid-FLUSH: returns to RUN next cycle, pend_flush and err_timeout cleared, counters cleared.

Test Plan:
- Reset, then idle inputs for 3 cycles -> all control outputs 0, busy_state=00, stall_cnt=0.
- ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> hazard=1, stall_if=stall_id=1 for one cycle; stall_cnt=1. Repeat with ex_rd=0 -> no hazard.
- dcache_req=1, dcache_ready low for 4 cycles then high -> memhazard high 5 cycles, busy_state=01 for 4 cycles, stall_cnt=5, err_timeout=0.
- ex_mispredict=1 on the first miss cycle, ready after 3 cycles -> no flush during DMISS; flush=1 exactly in the first RUN cycle; flush_cnt=1.
- ex_mispredict=1 together with a load-use match -> flush=1, hazard=0, if_kill=1. With FLUSH_CYCLES=3, flush is high 3 cycles and busy_state=10 for 2 cycles.
- dcache_ready held low 300 cycles (MISS_TIMEOUT=255) -> err_timeout rises at mcnt=255 and stays 1 after ready; rst clears it.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, D-cache miss
// freezes, mispredict flushes, performance counters and a miss-timeout flag.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MISS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        ex_mispredict,
   input  logic        dcache_req,
   input  logic        dcache_ready,
   input  logic        icache_ready,
   output logic        stall_if,
   output logic        stall_id,
   output logic        if_kill,
   output logic        hazard,
   output logic        flush,
   output logic        memhazard,
   output logic [1:0]  busy_state,
   output logic        err_timeout,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_DMISS = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   localparam logic [2:0] FCNT_INIT  = 3'(FLUSH_CYCLES - 32'd1);
   localparam logic [7:0] MCNT_LIMIT = 8'(MISS_TIMEOUT);

   state_t      r_state;
   logic [2:0]  r_fcnt;
   logic [7:0]  r_mcnt;
   logic        r_pend_flush;
   logic        r_err_timeout;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   state_t      w_state_nxt;
   logic [2:0]  w_fcnt_nxt;
   logic [7:0]  w_mcnt_nxt;
   logic        w_pend_nxt;
   logic        w_err_nxt;
   logic        w_flush_evt;
   logic        w_lu;
   logic        w_miss;

   assign w_lu = ex_memread && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
   assign w_miss = dcache_req && !dcache_ready;

   assign busy_state  = r_state;
   assign err_timeout = r_err_timeout;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_mcnt_nxt  = r_mcnt;
      w_pend_nxt  = r_pend_flush;
      w_err_nxt   = r_err_timeout;
      w_flush_evt = 1'b0;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      if_kill     = 1'b0;
      hazard      = 1'b0;
      flush       = 1'b0;
      memhazard   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_miss) begin
               // EX is frozen, so a simultaneous mispredict is remembered, not acted on
               memhazard   = 1'b1;
               stall_if    = 1'b1;
               stall_id    = 1'b1;
               w_state_nxt = ST_DMISS;
               w_mcnt_nxt  = 8'd1;
               w_pend_nxt  = r_pend_flush | ex_mispredict;
            end else if (ex_mispredict || r_pend_flush) begin
               flush       = 1'b1;
               if_kill     = 1'b1;
               w_flush_evt = 1'b1;
               w_pend_nxt  = 1'b0;
               if (FLUSH_CYCLES > 32'd1) begin
                  w_state_nxt = ST_FLUSH;
                  w_fcnt_nxt  = FCNT_INIT;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_fcnt_nxt  = 3'd0;
               end
            end else if (w_lu) begin
               hazard   = 1'b1;
               stall_if = 1'b1;
               stall_id = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DMISS: begin
            memhazard  = 1'b1;
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            w_mcnt_nxt = (r_mcnt == 8'hFF) ? r_mcnt : (r_mcnt + 8'd1);
            w_err_nxt  = r_err_timeout | (r_mcnt == MCNT_LIMIT);
            w_pend_nxt = r_pend_flush | ex_mispredict;
            if (dcache_ready) begin
               w_state_nxt = ST_RUN;
               w_mcnt_nxt  = 8'd0;
            end else begin
               w_state_nxt = ST_DMISS;
            end
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            if_kill = 1'b1;
            if (r_fcnt <= 3'd1) begin
               w_state_nxt = ST_RUN;
               w_fcnt_nxt  = 3'd0;
            end else begin
               w_state_nxt = ST_FLUSH;
               w_fcnt_nxt  = r_fcnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_fcnt_nxt  = 3'd0;
            w_mcnt_nxt  = 8'd0;
         end
      endcase
      // A held IF/ID keeps its instruction; otherwise a missing fetch becomes a bubble
      if (!icache_ready) begin
         stall_if = 1'b1;
         if_kill  = if_kill | ~stall_id;
      end else begin
         stall_if = stall_if;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_fcnt        <= 3'd0;
         r_mcnt        <= 8'd0;
         r_pend_flush  <= 1'b0;
         r_err_timeout <= 1'b0;
         r_stall_cnt   <= 32'd0;
         r_flush_cnt   <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_fcnt        <= w_fcnt_nxt;
         r_mcnt        <= w_mcnt_nxt;
         r_pend_flush  <= w_pend_nxt;
         r_err_timeout <= w_err_nxt;
         r_stall_cnt   <= r_stall_cnt + {31'd0, (memhazard | hazard)};
         r_flush_cnt   <= r_flush_cnt + {31'd0, w_flush_evt};
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a behavioural model
// of the stall/flush rules (miss in progress, flush cycles left, pending flush).
module tb_pipe_hazard_ctrl;

   localparam int TB_FLUSH   = 3;
   localparam int TB_TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_memread, ex_mispredict;
   logic        dcache_req, dcache_ready, icache_ready;
   logic        stall_if, stall_id, if_kill, hazard, flush, memhazard;
   logic [1:0]  busy_state;
   logic        err_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model state
   bit          m_miss;
   int          m_miss_cycles;
   int          m_flush_left;
   bit          m_pend;
   bit          m_err;
   logic [31:0] m_stalls;
   logic [31:0] m_flushes;

   // observation accumulators for directed windows
   int         acc_flush, acc_mem, acc_haz, acc_busy1, acc_busy2;
   logic [5:0] last_ctrl;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(TB_FLUSH), .MISS_TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_mispredict(ex_mispredict),
      .dcache_req(dcache_req), .dcache_ready(dcache_ready), .icache_ready(icache_ready),
      .stall_if(stall_if), .stall_id(stall_id), .if_kill(if_kill), .hazard(hazard),
      .flush(flush), .memhazard(memhazard), .busy_state(busy_state),
      .err_timeout(err_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic set_idle();
      rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = 5'd0; ex_memread = 1'b0; ex_mispredict = 1'b0;
      dcache_req = 1'b0; dcache_ready = 1'b0; icache_ready = 1'b1;
   endtask

   task automatic clr_acc();
      acc_flush = 0; acc_mem = 0; acc_haz = 0; acc_busy1 = 0; acc_busy2 = 0;
   endtask

   task automatic model_clear();
      m_miss = 0; m_miss_cycles = 0; m_flush_left = 0; m_pend = 0; m_err = 0;
      m_stalls = 32'd0; m_flushes = 32'd0;
   endtask

   // One clock: check outputs against the model, clock, advance the model, check registers
   task automatic cycle();
      bit lu, e_sif, e_sid, e_kill, e_haz, e_fl, e_mem;
      logic [1:0] e_busy;
      #1;
      lu = ex_memread && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      {e_sif, e_sid, e_kill, e_haz, e_fl, e_mem} = '0;
      if (m_miss) begin
         e_mem = 1; e_sif = 1; e_sid = 1; e_busy = 2'b01;
      end else if (m_flush_left > 0) begin
         e_fl = 1; e_kill = 1; e_busy = 2'b10;
      end else begin
         e_busy = 2'b00;
         if (dcache_req && !dcache_ready) begin
            e_mem = 1; e_sif = 1; e_sid = 1;
         end else if (ex_mispredict || m_pend) begin
            e_fl = 1; e_kill = 1;
         end else if (lu) begin
            e_haz = 1; e_sif = 1; e_sid = 1;
         end
      end
      if (!icache_ready) begin
         e_sif = 1;
         if (!e_sid) e_kill = 1;
      end
      last_ctrl = {stall_if, stall_id, if_kill, hazard, flush, memhazard};
      chk("ctrl", {26'd0, last_ctrl}, {26'd0, e_sif, e_sid, e_kill, e_haz, e_fl, e_mem});
      chk("busy_state", {30'd0, busy_state}, {30'd0, e_busy});
      acc_flush += int'(flush); acc_mem += int'(memhazard); acc_haz += int'(hazard);
      acc_busy1 += int'(busy_state == 2'b01); acc_busy2 += int'(busy_state == 2'b10);
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         if (e_mem || e_haz) m_stalls++;
         if (m_miss) begin
            m_miss_cycles++;
            if (m_miss_cycles >= TB_TIMEOUT) m_err = 1;
            if (ex_mispredict) m_pend = 1;
            if (dcache_ready) m_miss = 0;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (dcache_req && !dcache_ready) begin
            m_miss = 1; m_miss_cycles = 0;
            if (ex_mispredict) m_pend = 1;
         end else if (ex_mispredict || m_pend) begin
            m_flushes++; m_pend = 0; m_flush_left = TB_FLUSH - 1;
         end
      end
      #1;
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
      chk("stall_cnt", stall_cnt, m_stalls);
      chk("flush_cnt", flush_cnt, m_flushes);
   endtask

   task automatic do_reset();
      set_idle(); rst = 1'b1; cycle(); rst = 1'b0;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      do_reset();

      // idle after reset
      clr_acc();
      repeat (3) cycle();
      chk("idle_ctrl", {26'd0, last_ctrl}, 32'd0);
      chk("idle_busy", {30'd0, busy_state}, 32'd0);
      chk("idle_stall_cnt", stall_cnt, 32'd0);

      // load-use on rs2, then the same with ex_rd=0
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      cycle();
      chk("lu_ctrl", {26'd0, last_ctrl}, {26'd0, 6'b110100});
      set_idle(); cycle();
      chk("lu_stall_cnt", stall_cnt, 32'd1);
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
      cycle();
      chk("lu_rd0_ctrl", {26'd0, last_ctrl}, 32'd0);
      set_idle();

      // plain D-cache miss: 4 cycles not ready then ready
      do_reset(); clr_acc();
      dcache_req = 1'b1;
      repeat (4) cycle();
      dcache_ready = 1'b1; cycle();
      set_idle(); cycle();
      chk("miss_mem_cycles", acc_mem, 5);
      chk("miss_busy1_cycles", acc_busy1, 4);
      chk("miss_stall_cnt", stall_cnt, 32'd5);
      chk("miss_err", {31'd0, err_timeout}, 32'd0);

      // mispredict captured during a miss, fires in the first RUN cycle
      do_reset(); clr_acc();
      dcache_req = 1'b1; ex_mispredict = 1'b1; cycle();
      ex_mispredict = 1'b0;
      repeat (3) cycle();
      dcache_ready = 1'b1; cycle();
      chk("pend_no_flush_in_miss", acc_flush, 0);
      set_idle(); cycle();
      chk("pend_flush_first_run", {31'd0, last_ctrl[1]}, 32'd1);
      chk("pend_flush_cnt", flush_cnt, 32'd1);
      repeat (3) cycle();

      // mispredict beats load-use; flush held FLUSH_CYCLES
      do_reset(); clr_acc();
      ex_mispredict = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      cycle();
      chk("mp_lu_ctrl", {26'd0, last_ctrl}, {26'd0, 6'b001010});
      set_idle();
      repeat (3) cycle();
      chk("mp_flush_cycles", acc_flush, 3);
      chk("mp_busy2_cycles", acc_busy2, 2);
      chk("mp_hazard_cycles", acc_haz, 0);

      // miss timeout
      do_reset();
      dcache_req = 1'b1;
      repeat (300) cycle();
      chk("timeout_set", {31'd0, err_timeout}, 32'd1);
      dcache_ready = 1'b1; cycle();
      set_idle(); cycle();
      chk("timeout_sticky", {31'd0, err_timeout}, 32'd1);
      dcache_req = 1'b1; ex_mispredict = 1'b1;
      repeat (3) cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      set_idle(); cycle();
      chk("timeout_cleared", {31'd0, err_timeout}, 32'd0);
      chk("rst_mid_miss_flush_cnt", flush_cnt, 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom_range(0, 99) < 1);
         dcache_req    = ($urandom_range(0, 99) < 30);
         dcache_ready  = ($urandom_range(0, 99) < 40);
         ex_mispredict = ($urandom_range(0, 99) < 12);
         ex_memread    = ($urandom_range(0, 99) < 50);
         icache_ready  = ($urandom_range(0, 99) < 85);
         id_uses_rs1   = 1'($urandom_range(0, 1));
         id_uses_rs2   = 1'($urandom_range(0, 1));
         ex_rd         = 5'($urandom_range(0, 3));
         id_rs1        = 5'($urandom_range(0, 3));
         id_rs2        = 5'($urandom_range(0, 3));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
